// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared defaults, controller state type and FIFO pointer helper
// for the SRAM port controller.
package sram_ctrl_pkg;
    localparam int BITS_DEF   = 7;
    localparam int DEPTH_DEF  = 128;
    localparam int ADDR_W_DEF = 7;
    localparam int FIFO_DEPTH = 3;

    typedef enum logic {INIT, RUN} state_t;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/sram_resp_fifo.sv
// sram_resp_fifo: 3-entry show-ahead response FIFO; the head entry stays put until
// popped, so the read data is stable while the consumer stalls.
module sram_resp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int W = BITS_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [FIFO_DEPTH];
    logic [1:0]   r_wptr;
    logic [1:0]   r_rptr;
    logic [1:0]   r_count;
    logic         w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_valid = r_count != 2'd0;
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_push)
            r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 2'd0;
        end else begin
            if (i_push)
                r_wptr <= ptr_inc(r_wptr);
            if (w_pop)
                r_rptr <= ptr_inc(r_rptr);
            r_count <= r_count + 2'(i_push) - 2'(w_pop);
        end
    end
endmodule

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: valid/ready front end for a single-port synchronous SRAM macro,
// zeroing the array after reset and returning reads through a credit-limited FIFO.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int BITS   = BITS_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BITS-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [BITS-1:0]   resp_rdata,
    output logic              init_done,
    output logic              sram_CEB,
    output logic              sram_WEB,
    output logic [ADDR_W-1:0] sram_A,
    output logic [BITS-1:0]   sram_D,
    input  logic [BITS-1:0]   sram_Q
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_a;
    logic [BITS-1:0]   r_d;
    logic              r_inflight;
    logic [1:0]        w_count;
    logic              w_init;
    logic              w_accept;

    assign w_init    = r_state == INIT;
    assign init_done = r_state == RUN;
    // Credits cover both queued responses and the read whose data is still in the macro.
    assign req_ready = !w_init && (({1'b0, w_count} + {2'b0, r_inflight}) < 3'd3);
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_state_nxt = r_state;
        sram_CEB    = 1'b1;
        sram_WEB    = 1'b1;
        sram_A      = r_a;
        sram_D      = r_d;
        if (reset) begin
            sram_CEB = 1'b1;
        end else if (w_init) begin
            sram_CEB = 1'b0;
            sram_WEB = 1'b0;
            sram_A   = r_cnt;
            sram_D   = '0;
            if (r_cnt == ADDR_W'(DEPTH - 1))
                w_state_nxt = RUN;
        end else if (w_accept) begin
            sram_CEB = 1'b0;
            sram_WEB = !req_write;
            sram_A   = req_addr;
            if (req_write)
                sram_D = req_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= INIT;
            r_cnt      <= '0;
            r_a        <= '0;
            r_d        <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_init ? r_cnt + 1'b1 : '0;
            r_a        <= sram_A;
            r_d        <= sram_D;
            r_inflight <= w_accept && !req_write;
        end
    end

    sram_resp_fifo #(.W(BITS)) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_push  (r_inflight),
        .i_data  (sram_Q),
        .i_pop   (resp_ready),
        .o_valid (resp_valid),
        .o_data  (resp_rdata),
        .o_count (w_count)
    );
endmodule
